// File: rtl/ex_forward_hazard_ctrl.sv
// EX-stage operand forwarding with load-use / memory-wait hazard control for a 5-stage pipeline.
// Optional stall-cycle counter enabled by defining HAZ_STALL_CNT_EN.
module ex_forward_hazard_ctrl #(
  parameter int NUM_OPS = 2,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_OPS*ADDR_W-1:0] addr_ID,
  input  logic [ADDR_W-1:0]         rd_EX,
  input  logic                      wb_en_EX,
  input  logic                      mem_read_EX,
  input  logic [ADDR_W-1:0]         rd_MEM,
  input  logic                      wb_en_MEM,
  input  logic                      mem_busy,
  output logic [NUM_OPS*2-1:0]      fwd_sel_EX,
  output logic                      stall_IF_ID,
  output logic                      bubble_EX,
  output logic                      freeze,
  output logic [1:0]                state_o
`ifdef HAZ_STALL_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FREEZE     = 2'b10
  } state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // The producer now in EX (newer) wins over the one in MEM; x0 never forwards,
  // and a load in EX cannot forward from MEM next cycle (it is stalled instead).
  function automatic logic [1:0] fwd_pick(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] rd_ex,
    input logic              wb_ex,
    input logic              ld_ex,
    input logic [ADDR_W-1:0] rd_mem,
    input logic              wb_mem
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (a != '0) begin
      if (wb_ex && !ld_ex && (rd_ex == a)) begin
        sel = SEL_MEM;
      end else if (wb_mem && (rd_mem == a)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  state_t                   state_p1;
  state_t                   state_nxt;
  logic [NUM_OPS*2-1:0]     fwd_sel_p1;
  logic [NUM_OPS*2-1:0]     fwd_sel_nxt;
  logic                     any_match;
  logic                     load_use;

  // ---- ID stage: hazard detection and early select computation ----
  always_comb begin
    any_match = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (addr_ID[i*ADDR_W +: ADDR_W] == rd_EX) begin
        any_match = 1'b1;
      end
    end
    load_use = mem_read_EX && wb_en_EX && (rd_EX != '0) && any_match;
  end

  assign freeze      = mem_busy;
  assign bubble_EX   = load_use && !mem_busy;
  assign stall_IF_ID = freeze || bubble_EX;

  always_comb begin
    fwd_sel_nxt = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      fwd_sel_nxt[i*2 +: 2] = fwd_pick(addr_ID[i*ADDR_W +: ADDR_W], rd_EX, wb_en_EX,
                                       mem_read_EX, rd_MEM, wb_en_MEM);
    end
  end

  // ---- ID/EX boundary: registered forward selects ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fwd_sel_p1 <= '0;
    end else if (freeze) begin
      fwd_sel_p1 <= fwd_sel_p1;
    end else if (bubble_EX) begin
      fwd_sel_p1 <= '0;
    end else begin
      fwd_sel_p1 <= fwd_sel_nxt;
    end
  end

  assign fwd_sel_EX = fwd_sel_p1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_p1 <= RUN;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Memory wait dominates everything; leaving FREEZE goes straight to RUN even if a
  // load-use stall is raised in that same cycle.
  always_comb begin
    state_nxt = state_p1;
    if (mem_busy) begin
      state_nxt = FREEZE;
    end else begin
      unique case (state_p1)
        RUN:        state_nxt = load_use ? LOAD_STALL : RUN;
        LOAD_STALL: state_nxt = RUN;
        FREEZE:     state_nxt = RUN;
        default:    state_nxt = RUN;
      endcase
    end
  end

  assign state_o = state_p1;

`ifdef HAZ_STALL_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_cnt_p1;

  always_ff @(posedge CLK) begin
    if (RESET || cnt_clr) begin
      stall_cnt_p1 <= '0;
    end else if (stall_IF_ID) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign stall_cnt = stall_cnt_p1;
`else
  // Counter absent; CNT_W stays in the parameter list so both builds share one interface.
  if (CNT_W > 0) begin : g_no_stall_cnt
  end
`endif

endmodule

// File: tb/tb_ex_forward_hazard_ctrl.sv
// Directed + randomized bench for ex_forward_hazard_ctrl against a behavioural reference model.
module tb_ex_forward_hazard_ctrl;
  localparam int NUM_OPS = 2;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;

  logic                      CLK = 1'b0;
  logic                      RESET;
  logic [NUM_OPS*ADDR_W-1:0] addr_ID;
  logic [ADDR_W-1:0]         rd_EX;
  logic                      wb_en_EX;
  logic                      mem_read_EX;
  logic [ADDR_W-1:0]         rd_MEM;
  logic                      wb_en_MEM;
  logic                      mem_busy;
  logic [NUM_OPS*2-1:0]      fwd_sel_EX;
  logic                      stall_IF_ID;
  logic                      bubble_EX;
  logic                      freeze;
  logic [1:0]                state_o;
`ifdef HAZ_STALL_CNT_EN
  logic                      cnt_clr;
  logic [CNT_W-1:0]          stall_cnt;
`endif

  always #5 CLK = ~CLK;

  ex_forward_hazard_ctrl #(.NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .addr_ID(addr_ID), .rd_EX(rd_EX), .wb_en_EX(wb_en_EX),
    .mem_read_EX(mem_read_EX), .rd_MEM(rd_MEM), .wb_en_MEM(wb_en_MEM), .mem_busy(mem_busy),
    .fwd_sel_EX(fwd_sel_EX), .stall_IF_ID(stall_IF_ID), .bubble_EX(bubble_EX),
    .freeze(freeze), .state_o(state_o)
`ifdef HAZ_STALL_CNT_EN
    , .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: expected selects per operand, FSM state (0 run, 1 load stall, 2 freeze), counter.
  int m_sel [NUM_OPS];
  int m_state = 0;
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int op_addr(input int i);
    return int'(addr_ID[i*ADDR_W +: ADDR_W]);
  endfunction

  function automatic bit m_load_use();
    bit hit = 0;
    if (!(mem_read_EX && wb_en_EX && rd_EX != 0)) return 0;
    for (int i = 0; i < NUM_OPS; i++) if (op_addr(i) == int'(rd_EX)) hit = 1;
    return hit;
  endfunction

  function automatic logic [31:0] m_sel_packed();
    logic [31:0] v = 0;
    for (int i = 0; i < NUM_OPS; i++) v = v | (32'(m_sel[i]) << (2*i));
    return v;
  endfunction

  // One clock: check combinational outputs, predict the edge, then check registered outputs.
  task automatic step(input string tag);
    bit lu, mb, st, bb;
    int ns [NUM_OPS];
    int nstate;
    #1;
    lu = m_load_use();
    mb = mem_busy;
    bb = lu && !mb;
    st = mb || bb;
    check({tag, ".freeze"}, 32'(freeze), 32'(mb));
    check({tag, ".stall"}, 32'(stall_IF_ID), 32'(st));
    check({tag, ".bubble"}, 32'(bubble_EX), 32'(bb));
    for (int i = 0; i < NUM_OPS; i++) begin
      int a = op_addr(i);
      if (RESET || bb) ns[i] = 0;
      else if (mb) ns[i] = m_sel[i];
      else if (a != 0 && wb_en_EX && !mem_read_EX && int'(rd_EX) == a) ns[i] = 1;
      else if (a != 0 && wb_en_MEM && int'(rd_MEM) == a) ns[i] = 2;
      else ns[i] = 0;
    end
    if (RESET) nstate = 0;
    else if (mb) nstate = 2;
    else if (m_state == 0 && lu) nstate = 1;
    else nstate = 0;
`ifdef HAZ_STALL_CNT_EN
    if (RESET || cnt_clr) m_cnt = 0;
    else if (st && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
`endif
    @(posedge CLK);
    #1;
    for (int i = 0; i < NUM_OPS; i++) m_sel[i] = ns[i];
    m_state = nstate;
    check({tag, ".fwd_sel"}, 32'(fwd_sel_EX), m_sel_packed());
    check({tag, ".state"}, 32'(state_o), 32'(m_state));
`ifdef HAZ_STALL_CNT_EN
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic idle_inputs();
    addr_ID = '0; rd_EX = '0; wb_en_EX = 0; mem_read_EX = 0;
    rd_MEM = '0; wb_en_MEM = 0; mem_busy = 0;
`ifdef HAZ_STALL_CNT_EN
    cnt_clr = 0;
`endif
  endtask

  initial begin
    for (int i = 0; i < NUM_OPS; i++) m_sel[i] = 0;
    RESET = 1;
    idle_inputs();
    step("rst0");
    step("rst1");
    check("rst.fwd_sel", 32'(fwd_sel_EX), 32'h0);
    check("rst.state", 32'(state_o), 32'h0);
    check("rst.stall", 32'(stall_IF_ID), 32'h0);
    check("rst.bubble", 32'(bubble_EX), 32'h0);
    check("rst.freeze", 32'(freeze), 32'h0);

    RESET = 0;
    wb_en_EX = 1; rd_EX = 5; addr_ID = {5'd5, 5'd5};
    step("alu_ex");
    check("alu_ex.const", 32'(fwd_sel_EX), 32'b0101);
    wb_en_EX = 0; rd_EX = 0; wb_en_MEM = 1; rd_MEM = 5;
    step("alu_mem");
    check("alu_mem.const", 32'(fwd_sel_EX), 32'b1010);
    wb_en_EX = 1; rd_EX = 5;
    step("alu_both");
    check("alu_both.const", 32'(fwd_sel_EX), 32'b0101);

    wb_en_MEM = 0; rd_MEM = 0; rd_EX = 7; mem_read_EX = 1; wb_en_EX = 1;
    addr_ID = {5'd7, 5'd3};
    #1;
    check("load.stall_now", 32'(stall_IF_ID), 32'h1);
    check("load.bubble_now", 32'(bubble_EX), 32'h1);
    step("load");
    check("load.sel_const", 32'(fwd_sel_EX), 32'b0000);
    check("load.state_const", 32'(state_o), 32'b01);
    mem_read_EX = 0; wb_en_EX = 0; rd_EX = 0; rd_MEM = 7; wb_en_MEM = 1;
    step("load_after");
    check("load_after.sel_const", 32'(fwd_sel_EX), 32'b1000);
    check("load_after.state_const", 32'(state_o), 32'b00);

    idle_inputs();
    wb_en_EX = 1; rd_EX = 0; addr_ID = {5'd9, 5'd0};
    step("x0");
    check("x0.sel_const", 32'(fwd_sel_EX), 32'b0000);
    check("x0.stall_const", 32'(stall_IF_ID), 32'h0);

    rd_EX = 4; addr_ID = {5'd4, 5'd4};
    step("pre_frz");
    mem_busy = 1; mem_read_EX = 1;
    for (int k = 0; k < 3; k++) begin
      step("frz");
      check("frz.freeze_const", 32'(freeze), 32'h1);
      check("frz.bubble_const", 32'(bubble_EX), 32'h0);
      check("frz.sel_held", 32'(fwd_sel_EX), 32'b0101);
      check("frz.state_const", 32'(state_o), 32'b10);
    end
    mem_busy = 0;
    #1;
    check("unfrz.bubble_now", 32'(bubble_EX), 32'h1);
    step("unfrz");
    check("unfrz.state_const", 32'(state_o), 32'b00);

    mem_busy = 1;
    step("frz2a");
    step("frz2b");
    RESET = 1;
    step("rst_frz");
    check("rst_frz.state_const", 32'(state_o), 32'b00);
    check("rst_frz.sel_const", 32'(fwd_sel_EX), 32'b0000);
    RESET = 0;
    idle_inputs();
    step("post_rst");

`ifdef HAZ_STALL_CNT_EN
    cnt_clr = 1;
    step("cnt_clr0");
    cnt_clr = 0; mem_busy = 1;
    for (int k = 0; k < 20; k++) step("cnt_sat");
    check("cnt_sat.const", 32'(stall_cnt), 32'd15);
    mem_busy = 0; cnt_clr = 1;
    step("cnt_clr");
    check("cnt_clr.const", 32'(stall_cnt), 32'd0);
    cnt_clr = 0;
`endif

    for (int k = 0; k < 400; k++) begin
      RESET       = ($urandom_range(0, 49) == 0);
      mem_busy    = ($urandom_range(0, 4) == 0);
      mem_read_EX = ($urandom_range(0, 2) == 0);
      wb_en_EX    = $urandom_range(0, 1) == 1;
      wb_en_MEM   = $urandom_range(0, 1) == 1;
      rd_EX       = ADDR_W'($urandom_range(0, 3));
      rd_MEM      = ADDR_W'($urandom_range(0, 3));
      for (int i = 0; i < NUM_OPS; i++) addr_ID[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
`ifdef HAZ_STALL_CNT_EN
      cnt_clr     = ($urandom_range(0, 29) == 0);
`endif
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
